// File: rtl/router_pkg.sv
// Shared router definitions: flit type codes, flit field positions, header field
// widths and the encapsulator FSM encoding.
package router_pkg;

  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int HDR_LSB     = 0;
  localparam int DST_LSB     = 9;
  localparam int PAR_BIT     = 19;
  localparam int TYPE_LSB    = 22;
  localparam int PAYLOAD_LSB = 24;

  // Header layout: TTL[8:7], packet number[6:2], source router[1:0]
  localparam int TTL_W     = 2;
  localparam int PKT_NUM_W = 5;
  localparam int SRC_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HREQ,
    ST_HLATCH,
    ST_STREAM,
    ST_DONE
  } encap_state_e;

endpackage

// File: rtl/dfx_flit_builder.sv
// Combinational packing of one Aurora flit. With DFX_ENCAP_PARITY_EN defined,
// bit 19 carries even parity over all other populated flit bits.
module dfx_flit_builder
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int PAYLOAD_WIDTH     = 40,
  parameter int HEADER_WIDTH      = 9
) (
  input  logic [PAYLOAD_WIDTH-1:0]     payload,
  input  logic [1:0]                   flit_type,
  input  logic [ADDR_WIDTH-1:0]        dst_addr,
  input  logic [HEADER_WIDTH-1:0]      header,
  output logic [AURORA_DATA_WIDTH-1:0] flit
);

  always_comb begin
    flit = '0;
    flit[PAYLOAD_LSB +: PAYLOAD_WIDTH] = payload;
    flit[TYPE_LSB +: 2]                = flit_type;
    flit[DST_LSB +: ADDR_WIDTH]        = dst_addr;
    flit[HDR_LSB +: HEADER_WIDTH]      = header;
`ifdef DFX_ENCAP_PARITY_EN
    flit[PAR_BIT] = ^{payload, flit_type, dst_addr, header};
`endif
  end

endmodule

// File: rtl/dfx_encap.sv
// Packetiser feeding router input port 0: fetches a header, then frames
// FLITS_PER_PKT payload beats into flits. Optional parity: DFX_ENCAP_PARITY_EN.
module dfx_encap
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int PAYLOAD_WIDTH     = 40,
  parameter int FLITS_PER_PKT     = 4,
  parameter int HEADER_WIDTH      = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         encap_start,
  input  logic [PAYLOAD_WIDTH-1:0]     payload_in,
  input  logic                         payload_valid,
  output logic                         payload_ready,
  output logic                         ready_encap_dfx,
  input  logic [HEADER_WIDTH-1:0]      header_pkt_send,
  input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
  input  logic                         full_input_port_0,
  output logic                         we_input_port_0,
  output logic [AURORA_DATA_WIDTH-1:0] data_input_port_0,
  output logic                         encap_busy,
  output logic                         encap_done
);

  localparam int               CNT_W    = $clog2(FLITS_PER_PKT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLITS_PER_PKT - 1);

  encap_state_e                 state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [HEADER_WIDTH-1:0]      hdr_q, hdr_d;
  logic [ADDR_WIDTH-1:0]        dst_q, dst_d;
  logic                         we_q, we_d;
  logic [AURORA_DATA_WIDTH-1:0] data_q, data_d;
  logic                         req_q, req_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic                         accept;
  logic [1:0]                   flit_type;
  logic [AURORA_DATA_WIDTH-1:0] flit;

  assign payload_ready = (state_q == ST_STREAM) && !full_input_port_0;
  assign accept        = payload_ready && payload_valid;

  always_comb begin
    if (cnt_q == '0) begin
      flit_type = (FLITS_PER_PKT == 1) ? FLIT_SINGLE : FLIT_HEAD;
    end else if (cnt_q == LAST_CNT) begin
      flit_type = FLIT_TAIL;
    end else begin
      flit_type = FLIT_BODY;
    end
  end

  dfx_flit_builder #(
    .AURORA_DATA_WIDTH(AURORA_DATA_WIDTH),
    .ADDR_WIDTH       (ADDR_WIDTH),
    .PAYLOAD_WIDTH    (PAYLOAD_WIDTH),
    .HEADER_WIDTH     (HEADER_WIDTH)
  ) u_builder (
    .payload  (payload_in),
    .flit_type(flit_type),
    .dst_addr (dst_q),
    .header   (hdr_q),
    .flit     (flit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    dst_d   = dst_q;
    we_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      ST_IDLE:   if (encap_start) state_d = ST_HREQ;
      ST_HREQ: begin
        cnt_d   = '0;
        state_d = ST_HLATCH;
      end
      // The controller presents its header one cycle after our request pulse
      ST_HLATCH: begin
        hdr_d   = header_pkt_send;
        dst_d   = router_dst_addr_send;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept) begin
          we_d   = 1'b1;
          data_d = flit;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_HREQ);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      dst_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      dst_q   <= dst_d;
      we_q    <= we_d;
      data_q  <= data_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_encap_dfx   = req_q;
  assign we_input_port_0   = we_q;
  assign data_input_port_0 = data_q;
  assign encap_busy        = busy_q;
  assign encap_done        = done_q;

endmodule

// File: tb/tb_dfx_encap.sv
// Self-checking bench for dfx_encap (4-flit and 1-flit builds); expected flits
// come from a field-arithmetic model, honouring DFX_ENCAP_PARITY_EN when defined.
module tb_dfx_encap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        encap_start, payload_valid, payload_ready, ready_encap, full_p0;
  logic        we_p0, busy, done;
  logic [39:0] payload_in;
  logic [8:0]  hdr_in;
  logic [9:0]  dst_in;
  logic [63:0] data_p0;

  logic        s_start, s_valid, s_ready, s_rdy, s_full, s_we, s_busy, s_done;
  logic [39:0] s_payload;
  logic [8:0]  s_hdr;
  logic [9:0]  s_dst;
  logic [63:0] s_data;

  dfx_encap #(.FLITS_PER_PKT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .encap_start(encap_start), .payload_in(payload_in),
    .payload_valid(payload_valid), .payload_ready(payload_ready),
    .ready_encap_dfx(ready_encap), .header_pkt_send(hdr_in),
    .router_dst_addr_send(dst_in), .full_input_port_0(full_p0),
    .we_input_port_0(we_p0), .data_input_port_0(data_p0),
    .encap_busy(busy), .encap_done(done)
  );

  dfx_encap #(.FLITS_PER_PKT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .encap_start(s_start), .payload_in(s_payload),
    .payload_valid(s_valid), .payload_ready(s_ready),
    .ready_encap_dfx(s_rdy), .header_pkt_send(s_hdr),
    .router_dst_addr_send(s_dst), .full_input_port_0(s_full),
    .we_input_port_0(s_we), .data_input_port_0(s_data),
    .encap_busy(s_busy), .encap_done(s_done)
  );

  typedef struct {
    logic [8:0]       hdr;
    logic [9:0]       dst;
    logic [3:0][39:0] pl;
    int               mode;   // 0 clean, 1 random full/valid, 2 full for 3 cycles at beat 2
    bit               hold;
    logic [7:0]       types;  // expected type codes, flit 0 in the top bits
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] got_q[$];
  int req_cnt = 0, done_cnt = 0, last_we_cyc = 0, done_cyc = 0;
  logic full_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [63:0] model_flit(input logic [39:0] p, input int idx, input int n,
                                             input logic [8:0] h, input logic [9:0] d);
    logic [63:0] f;
    int t;
    if (n == 1) t = 3;
    else if (idx == 0) t = 1;
    else if (idx == n - 1) t = 2;
    else t = 0;
    f = (64'(p) << 24) | (64'(t) << 22) | (64'(d) << 9) | 64'(h);
`ifdef DFX_ENCAP_PARITY_EN
    if ($countones(f) % 2 == 1) f = f | (64'd1 << 19);
`endif
    return f;
  endfunction

  function automatic int next_pkt(input int n);
    return (n == 19) ? 1 : n + 1;
  endfunction

  function automatic vec_t mk_vec(input logic [8:0] h, input logic [9:0] d,
                                  input logic [3:0][39:0] pl, input int mode, input bit hold);
    vec_t v;
    v.hdr = h; v.dst = d; v.pl = pl; v.mode = mode; v.hold = hold;
    v.types = 8'b01_00_00_10;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we_p0) begin
      got_q.push_back(data_p0);
      last_we_cyc = cyc;
      check("no_write_while_full", 64'(full_prev), 64'd0);
    end
    if (ready_encap) req_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    full_prev = full_p0;
  end

  task automatic wait_req(input int base, input string tag);
    int guard = 0;
    do begin @(negedge clk); #1; guard++; end while (req_cnt == base && guard < 20);
    if (req_cnt == base) timeout({tag, " req"});
  endtask

  task automatic run_packet(input vec_t v, input string tag);
    int base_req, base_done, guard, full_left;
    bit acc;
    got_q.delete();
    base_req  = req_cnt;
    base_done = done_cnt;
    @(posedge clk); #1;
    encap_start = 1'b1;
    hdr_in = 9'h1FF; dst_in = 10'h3FF;
    wait_req(base_req, tag);
    @(posedge clk); #1;                 // HLATCH: controller presents header now
    hdr_in = v.hdr; dst_in = v.dst;
    if (!v.hold) encap_start = 1'b0;
    @(posedge clk); #1;
    hdr_in = ~v.hdr; dst_in = ~v.dst;
    full_left = 3;
    for (int i = 0; i < 4; i++) begin
      payload_in = v.pl[i];
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 60) begin
        case (v.mode)
          0: begin full_p0 = 1'b0; payload_valid = 1'b1; end
          1: begin
            full_p0 = ($urandom_range(0, 2) == 0);
            payload_valid = ($urandom_range(0, 3) != 0);
          end
          default: begin
            full_p0 = (i == 2 && full_left > 0);
            if (full_p0) full_left--;
            payload_valid = 1'b1;
          end
        endcase
        @(negedge clk); #1;
        check({tag, " payload_ready"}, 64'(payload_ready), 64'(!full_p0));
        if (i == 0 && guard == 0) check({tag, " busy"}, 64'(busy), 64'd1);
        acc = payload_valid && !full_p0;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        timeout({tag, " beat"});
        break;
      end
    end
    payload_valid = 1'b0;
    full_p0 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
      if (guard == 1) check({tag, " ready_after_tail"}, 64'(payload_ready), 64'd0);
    end while (done_cnt == base_done && guard < 10);
    if (done_cnt == base_done) timeout({tag, " done"});
    check({tag, " done_timing"}, 64'(done_cyc), 64'(last_we_cyc + 1));
    check({tag, " flit_count"}, 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check($sformatf("%s flit%0d", tag, i), got_q[i], model_flit(v.pl[i], i, 4, v.hdr, v.dst));
      check($sformatf("%s type%0d", tag, i), 64'(got_q[i][23:22]), 64'(v.types[(3-i)*2 +: 2]));
    end
    check({tag, " req_pulses"}, 64'(req_cnt - base_req), 64'd1);
    $display("packet %s: %0d flits, hdr %h dst %h", tag, got_q.size(), v.hdr, v.dst);
  endtask

  vec_t tbl[6];

  initial begin
    int pn, guard, base_req, we_n, we_c, dn_c;
    logic [63:0] s_got;

    rst_n = 1'b0;
    encap_start = 0; payload_in = '0; payload_valid = 0; hdr_in = '0; dst_in = '0; full_p0 = 0;
    s_start = 0; s_valid = 0; s_payload = '0; s_hdr = '0; s_dst = '0; s_full = 0;

    tbl[0] = mk_vec(9'h10A, 10'h155, {40'h4, 40'h3, 40'h2, 40'h1}, 0, 1'b0);
    tbl[1] = mk_vec(9'h0C3, 10'h2AA, {40'($urandom), 40'($urandom), 40'($urandom), 40'($urandom)}, 2, 1'b0);
    pn = 18;
    for (int k = 2; k <= 4; k++) begin
      tbl[k] = mk_vec({2'b11, 5'(pn), 2'b01}, 10'($urandom),
                      {{8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
                       {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)}},
                      (k == 4) ? 0 : 1, k != 4);
      pn = next_pkt(pn);
    end
    tbl[5] = mk_vec(9'h000, 10'h000, {40'h9, 40'h7, 40'h1, 40'h5}, 0, 1'b0);

    #23;
    check("reset_ctrl", 64'({payload_ready, ready_encap, we_p0, busy, done}), 64'd0);
    check("reset_data", data_p0, 64'd0);
    check("reset_ctrl_f1", 64'({s_ready, s_rdy, s_we, s_busy, s_done}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_packet(tbl[k], $sformatf("vec%0d", k));
    check("wrap_pktnum", 64'(tbl[4].hdr[6:2]), 64'(got_q.size() == 0 ? 5'h1F : 5'd1));
    if (got_q.size() > 1) begin
`ifdef DFX_ENCAP_PARITY_EN
      check("parity_bit19", 64'(got_q[1][19]), 64'd1);
`else
      check("parity_bit19", 64'(got_q[1][19]), 64'd0);
`endif
    end

    // Reset mid-packet after the second flit is written
    got_q.delete();
    base_req = req_cnt;
    @(posedge clk); #1; encap_start = 1'b1;
    wait_req(base_req, "rst");
    @(posedge clk); #1; hdr_in = 9'h10A; dst_in = 10'h155; encap_start = 1'b0;
    @(posedge clk); #1; payload_valid = 1'b1; full_p0 = 1'b0; payload_in = 40'hA;
    guard = 0;
    while (got_q.size() < 2 && guard < 20) begin @(negedge clk); #1; guard++; end
    if (got_q.size() < 2) timeout("rst two_flits");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({payload_ready, ready_encap, we_p0, busy, done}), 64'd0);
    check("midrst_data", data_p0, 64'd0);
    payload_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("midrst_flits", 64'(got_q.size()), 64'd2);
    run_packet(tbl[0], "after_rst");

    // Single-flit build
    @(posedge clk); #1; s_start = 1'b1; s_hdr = 9'h1FF; s_dst = 10'h3FF;
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (!s_rdy && guard < 20);
    if (!s_rdy) timeout("f1 req");
    @(posedge clk); #1; s_hdr = 9'h055; s_dst = 10'h0AB; s_start = 1'b0;
    @(posedge clk); #1; s_hdr = 9'h000; s_dst = 10'h000; s_payload = 40'hFF; s_valid = 1'b1;
    @(negedge clk); #1;
    check("f1 payload_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1; s_valid = 1'b0;
    we_n = 0; we_c = -1; dn_c = -1; s_got = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (s_we) begin we_n++; we_c = c; s_got = s_data; end
      if (s_done) dn_c = c;
    end
    check("f1 write_count", 64'(we_n), 64'd1);
    check("f1 flit", s_got, model_flit(40'hFF, 0, 1, 9'h055, 10'h0AB));
    check("f1 type", 64'(s_got[23:22]), 64'd3);
    check("f1 done_timing", 64'(dn_c), 64'(we_c + 1));
    $display("packet f1: %0d flits, flit %h", we_n, s_got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
